i2s_rx_lite: RTL and testbench
==============================

Name: i2s_rx_lite

Overview:
I2S slave receiver, the capture-side counterpart of the AMP3 Lite transmitter. It samples externally driven BCLK/LRCLK/SDATA in the system clock domain and deserialises one left and one right sample per frame. It presents the samples as parallel words with per-channel valid strobes. Used for line-in/mic Pmods and as a loopback checker for the AMP3 transmit path.

Parameters:
DATA_WIDTH, 12, bits captured per channel (MSB-first, left-aligned)
SYNC_STAGES, 2, flip-flop stages on each pin input (min 2)

Ports:
clk  input  1  system clock; must be >= 8x BCLK frequency
rst  input  1  synchronous, active-high reset
enable  input  1  receiver runs while high; low forces IDLE
BCLK  input  1  external bit clock (asynchronous to clk)
LRCLK  input  1  external word select; 0 = left, 1 = right
SDATA  input  1  external serial data
dataL  output  DATA_WIDTH  last complete left sample
dataR  output  DATA_WIDTH  last complete right sample
validL  output  1  one-clk pulse when dataL updates
validR  output  1  one-clk pulse when dataR updates
RightNLeft  output  1  channel currently being shifted in (synchronised LRCLK)
aligned  output  1  high once the first full word boundary has been seen since enable

Behaviour:
- Reset (rst=1 at a clk edge): dataL=dataR=0, validL=validR=0, RightNLeft=0, aligned=0, state=IDLE, shift register and bit counter cleared, sync chains cleared.
- All three pins pass through SYNC_STAGES flops. BCLK rise = synced BCLK 1 while the previous synced value was 0. All capture acts only on BCLK rise; BCLK fall is ignored.
- lr_prev holds the synced LRCLK value as of the last BCLK rise.
- I2S framing (one-bit delay): the BCLK rise on which LRCLK differs from lr_prev carries the LSB of the previous channel's word. The next rise carries the MSB of channel LRCLK.
- States:
  - IDLE: enable=0. Outputs hold, strobes 0. On enable=1, go to SEEK.
  - SEEK: wait for an LRCLK change on a BCLK rise. Discard that bit, clear the counter, set aligned=1, go to SHIFT. No word is committed from SEEK, so a partial first word is never output.
  - SHIFT, each BCLK rise:
    - if bitcnt < DATA_WIDTH, shift SDATA into the shift register and increment bitcnt; otherwise drop the bit (counter saturates at DATA_WIDTH).
    - on an LRCLK-change rise: include that bit under the same rule, then commit. Word = shift register left-aligned, zero-padded in the LSBs if fewer than DATA_WIDTH bits arrived.
    - commit writes dataL when lr_prev=0 or dataR when lr_prev=1, and pulses the matching valid. Then clear bitcnt and update lr_prev.
- Latency: outputs and strobe change on the 3rd clk edge counting the edge that first registers BCLK high at the pin flop (SYNC_STAGES=2). Strobe is high exactly 1 clk.
- Slots longer than DATA_WIDTH: extra LSBs are discarded. Shorter slots: zero padded. A 1-bit slot is valid.
- enable falls mid-word: go to IDLE on the next clk. Discard the partial word, aligned=0, outputs hold. Re-enable re-enters SEEK.
- rst mid-word: full reset as above. Takes priority over enable.
- validL and validR are never high in the same cycle. BCLK rises are at least 8 clk apart by the clock-ratio requirement.
- RightNLeft = synced LRCLK in all states except IDLE, where it holds 0.

Decomposition:
- Shared package/header:
  - state encoding IDLE/SEEK/SHIFT
  - channel constants LEFT=0, RIGHT=1
  - I2S one-bit-delay convention, shared with the AMP3 transmitter
- One natural sub-module: i2s_pin_sync. Parameterised multi-bit synchroniser plus rise detector, instantiated once for {BCLK, LRCLK, SDATA}.

Test Plan:
- Loopback from amp3_Lite with dataR=12'hFFF, dataL=12'h000, enable=1 -> after SEEK, validL pulses with dataL=12'h000 and validR pulses with dataR=12'hFFF, alternating every frame.
- Stimulus of 16-bit slots, left=16'hA5C3, right=16'h1234 -> dataL=12'hA5C, dataR=12'h123 (LSBs dropped).
- Stimulus of 8-bit slots, left=8'hB7 -> dataL=12'hB70 (zero-padded).
- enable rises mid right-slot -> no validR for the partial word, aligned rises on the next LRCLK change, first output is a complete left word.
- enable dropped mid-left-word, then re-asserted -> no validL from the broken word, previously captured dataL/dataR held throughout.
- rst pulsed for 1 clk mid-frame -> all outputs 0 on the next clk, no strobes until a new LRCLK boundary passes; BCLK = clk/8 for a latency check of the 3-edge rule.

Source files
------------

// File: rtl/i2s_rx_lite_pkg.sv
// Shared types and constants for the I2S slave receiver.
// The framing helper is the same one-bit-delay rule that the AMP3 transmitter follows.
package i2s_rx_lite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam int unsigned PIN_BCLK  = 0;
    localparam int unsigned PIN_LRCLK = 1;
    localparam int unsigned PIN_SDATA = 2;
    localparam int unsigned PIN_W     = 3;

    // The BCLK rise on which LRCLK has changed carries the old channel's LSB;
    // the rise after it carries the new channel's MSB.
    function automatic logic lsb_slot_edge(input logic lr, input logic lr_prev);
        return lr != lr_prev;
    endfunction

endpackage

// File: rtl/i2s_rx_lite_if.sv
// I2S pin and sample bus between an external I2S source and the receiver.
interface i2s_rx_lite_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  BCLK;
    logic                  LRCLK;
    logic                  SDATA;
    logic [DATA_WIDTH-1:0] dataL;
    logic [DATA_WIDTH-1:0] dataR;
    logic                  validL;
    logic                  validR;
    logic                  RightNLeft;
    logic                  aligned;

    modport master (
        output BCLK, LRCLK, SDATA,
        input  dataL, dataR, validL, validR, RightNLeft, aligned
    );

    modport slave (
        input  BCLK, LRCLK, SDATA,
        output dataL, dataR, validL, validR, RightNLeft, aligned
    );
endinterface

// File: rtl/i2s_rx_lite_pin_sync.sv
// Multi-bit pin synchroniser. Lane 0 is the strobe lane and is reported only as a
// rise pulse; lanes 1 and up are delivered as synchronised levels.
module i2s_rx_lite_pin_sync #(
    parameter int unsigned W      = 3,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:1] q,
    output logic         rise_c
);

    logic [W-1:0] stage_q [STAGES];
    logic [W-1:0] stage_d [STAGES];
    logic         prev_q;
    logic         prev_d;

    always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        prev_d = stage_q[STAGES-1][0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
        end
    end

    assign q      = stage_q[STAGES-1][W-1:1];
    assign rise_c = stage_q[STAGES-1][0] & ~prev_q;

endmodule

// File: rtl/i2s_rx_lite.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA in the clk domain and
// deserialises one left and one right sample per frame, MSB first, left aligned.
module i2s_rx_lite
    import i2s_rx_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    i2s_rx_lite_if.slave bus
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [PIN_W-1:0]      pins_raw;
    logic [PIN_W-1:1]      pins_sync;
    logic                  bclk_rise_c;
    logic                  lr_sync;
    logic                  sdata_sync;

    state_t                state_q, state_d;
    logic                  lr_prev_q, lr_prev_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0] data_l_q, data_l_d;
    logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
    logic                  valid_l_q, valid_l_d;
    logic                  valid_r_q, valid_r_d;
    logic                  aligned_q, aligned_d;
    logic                  rnl_q, rnl_d;

    logic [DATA_WIDTH-1:0] sh_next;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] word;
    logic                  boundary;

    always_comb begin
        pins_raw            = '0;
        pins_raw[PIN_BCLK]  = bus.BCLK;
        pins_raw[PIN_LRCLK] = bus.LRCLK;
        pins_raw[PIN_SDATA] = bus.SDATA;
    end

    i2s_rx_lite_pin_sync #(
        .W      (PIN_W),
        .STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (pins_raw),
        .q      (pins_sync),
        .rise_c (bclk_rise_c)
    );

    assign lr_sync    = pins_sync[PIN_LRCLK];
    assign sdata_sync = pins_sync[PIN_SDATA];

    // Next-state, capture and commit logic; everything advances on BCLK rises only.
    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        data_l_d  = data_l_q;
        data_r_d  = data_r_q;
        valid_l_d = 1'b0;
        valid_r_d = 1'b0;
        aligned_d = aligned_q;
        sh_next   = shreg_q;
        cnt_next  = bitcnt_q;
        boundary  = bclk_rise_c && lsb_slot_edge(lr_sync, lr_prev_q);

        if (bclk_rise_c) begin
            lr_prev_d = lr_sync;
        end

        // Bits beyond DATA_WIDTH in a long slot are dropped; the counter saturates.
        if (bitcnt_q < CW'(DATA_WIDTH)) begin
            sh_next  = (shreg_q << 1) | DATA_WIDTH'(sdata_sync);
            cnt_next = bitcnt_q + CW'(1);
        end
        word = sh_next << (CW'(DATA_WIDTH) - cnt_next);

        unique case (state_q)
            IDLE: begin
                aligned_d = 1'b0;
                if (enable) begin
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (!enable) begin
                    state_d   = IDLE;
                    aligned_d = 1'b0;
                end else if (boundary) begin
                    shreg_d   = '0;
                    bitcnt_d  = '0;
                    aligned_d = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_d   = IDLE;
                    aligned_d = 1'b0;
                    shreg_d   = '0;
                    bitcnt_d  = '0;
                end else if (bclk_rise_c) begin
                    shreg_d  = sh_next;
                    bitcnt_d = cnt_next;
                    if (boundary) begin
                        if (lr_prev_q == RIGHT) begin
                            data_r_d  = word;
                            valid_r_d = 1'b1;
                        end else begin
                            data_l_d  = word;
                            valid_l_d = 1'b1;
                        end
                        shreg_d  = '0;
                        bitcnt_d = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                aligned_d = 1'b0;
            end
        endcase

        rnl_d = (state_d == IDLE) ? LEFT : lr_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lr_prev_q <= 1'b0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            data_l_q  <= '0;
            data_r_q  <= '0;
            valid_l_q <= 1'b0;
            valid_r_q <= 1'b0;
            aligned_q <= 1'b0;
            rnl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            data_l_q  <= data_l_d;
            data_r_q  <= data_r_d;
            valid_l_q <= valid_l_d;
            valid_r_q <= valid_r_d;
            aligned_q <= aligned_d;
            rnl_q     <= rnl_d;
        end
    end

    assign bus.dataL      = data_l_q;
    assign bus.dataR      = data_r_q;
    assign bus.validL     = valid_l_q;
    assign bus.validR     = valid_r_q;
    assign bus.aligned    = aligned_q;
    assign bus.RightNLeft = rnl_q;

endmodule

// File: tb/tb_i2s_rx_lite.sv
// Directed bench for i2s_rx_lite: I2S frames driven at BCLK = clk/8, expected
// words queued per slot and checked whenever a valid strobe appears.
module tb_i2s_rx_lite;

    typedef struct packed {
        logic        ch;
        logic [11:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    logic pend = 1'b0;
    logic [11:0] last_l = '0;
    logic [11:0] last_r = '0;

    i2s_rx_lite_if #(.DATA_WIDTH(12)) bus ();

    i2s_rx_lite #(
        .DATA_WIDTH  (12),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: left-align a len-bit slot word into 12 bits.
    function automatic logic [11:0] exp_word(input logic [31:0] w, input int len);
        logic [31:0] t;
        if (len >= 12) t = w >> (len - 12);
        else           t = w << (12 - len);
        return t[11:0];
    endfunction

    task automatic send_bit(input logic lr, input logic sd);
        bus.BCLK  = 1'b0;
        bus.LRCLK = lr;
        bus.SDATA = sd;
        repeat (4) @(negedge clk);
        bus.BCLK = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One I2S slot: first period carries the previous word's LSB.
    task automatic send_slot(input logic lr, input logic [31:0] w, input int len, input bit expect_it,
                             input int off_at, input int on_at, input int rst_at);
        if (expect_it) begin
            sbq.push_back('{ch: lr, data: exp_word(w, len)});
            if (lr) last_r = exp_word(w, len);
            else    last_l = exp_word(w, len);
        end
        for (int b = 0; b < len; b++) begin
            if (b == off_at) enable = 1'b0;
            if (b == on_at)  enable = 1'b1;
            if (b == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_mid_dataL", 32'(bus.dataL), 0);
                chk("rst_mid_dataR", 32'(bus.dataR), 0);
                chk("rst_mid_valid", 32'({bus.validL, bus.validR}), 0);
                chk("rst_mid_aligned", 32'(bus.aligned), 0);
                chk("rst_mid_rnl", 32'(bus.RightNLeft), 0);
                @(negedge clk);
                rst = 1'b0;
                last_l = '0;
                last_r = '0;
            end
            send_bit(lr, (b == 0) ? pend : w[len-b]);
        end
        pend = w[0];
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.validL || bus.validR)) begin
            chk("strobe_excl", 32'(bus.validL & bus.validR), 0);
            if (sbq.size() == 0) begin
                chk("spurious_strobe", 32'({bus.validL, bus.validR}), 0);
            end else begin
                e = sbq.pop_front();
                chk("strobe_ch", 32'(bus.validR), 32'(e.ch));
                chk("strobe_data", 32'(e.ch ? bus.dataR : bus.dataL), 32'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        bus.BCLK  = 1'b0;
        bus.LRCLK = 1'b0;
        bus.SDATA = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dataL", 32'(bus.dataL), 0);
        chk("reset_dataR", 32'(bus.dataR), 0);
        chk("reset_validL", 32'(bus.validL), 0);
        chk("reset_validR", 32'(bus.validR), 0);
        chk("reset_rnl", 32'(bus.RightNLeft), 0);
        chk("reset_aligned", 32'(bus.aligned), 0);
        rst    = 1'b0;
        enable = 1'b1;

        // Loopback-style alternating 12-bit frames
        send_slot(1'b0, 32'h000, 12, 1'b0, -1, -1, -1);
        chk("seek_aligned", 32'(bus.aligned), 0);
        chk("seek_rnl", 32'(bus.RightNLeft), 0);
        send_slot(1'b1, 32'hFFF, 12, 1'b1, -1, -1, -1);
        chk("locked_aligned", 32'(bus.aligned), 1);
        chk("locked_rnl", 32'(bus.RightNLeft), 1);
        send_slot(1'b0, 32'h000, 12, 1'b1, -1, -1, -1);
        send_slot(1'b1, 32'hFFF, 12, 1'b1, -1, -1, -1);
        send_slot(1'b0, 32'h000, 12, 1'b1, -1, -1, -1);
        send_slot(1'b1, 32'hFFF, 12, 1'b1, -1, -1, -1);

        // Long, short and 1-bit slots
        send_slot(1'b0, 32'hA5C3, 16, 1'b1, -1, -1, -1);
        send_slot(1'b1, 32'h1234, 16, 1'b1, -1, -1, -1);
        send_slot(1'b0, 32'hB7, 8, 1'b1, -1, -1, -1);
        send_slot(1'b1, 32'h5A, 8, 1'b1, -1, -1, -1);
        send_slot(1'b0, 32'h1, 1, 1'b1, -1, -1, -1);
        send_slot(1'b1, 32'h1, 1, 1'b1, -1, -1, -1);
        send_slot(1'b0, 32'h3C5, 12, 1'b1, -1, -1, -1);
        send_slot(1'b1, 32'hC3A, 12, 1'b1, -1, -1, -1);

        // Enable dropped mid-left word, then re-asserted
        send_slot(1'b0, 32'h6E1, 12, 1'b0, 5, 6, -1);
        chk("drop_hold_dataL", 32'(bus.dataL), 32'(last_l));
        chk("drop_hold_dataR", 32'(bus.dataR), 32'(last_r));
        chk("drop_aligned", 32'(bus.aligned), 0);
        chk("drop_queue_empty", 32'(sbq.size()), 0);
        send_slot(1'b1, 32'h2D7, 12, 1'b1, -1, -1, -1);

        // Enable rises mid right slot
        send_slot(1'b0, 32'h111, 12, 1'b0, 8, -1, -1);
        send_slot(1'b1, 32'h222, 12, 1'b0, -1, 4, -1);
        chk("late_en_aligned", 32'(bus.aligned), 0);
        chk("late_en_hold_dataR", 32'(bus.dataR), 32'(last_r));
        send_slot(1'b0, 32'h9F3, 12, 1'b1, -1, -1, -1);
        chk("late_en_aligned_up", 32'(bus.aligned), 1);
        send_slot(1'b1, 32'h4B8, 12, 1'b1, -1, -1, -1);

        // Reset pulse mid-left word
        send_slot(1'b0, 32'h777, 12, 1'b0, -1, -1, 5);
        send_slot(1'b1, 32'hABC, 12, 1'b1, -1, -1, -1);

        // Latency: strobe on the 3rd clk edge after BCLK high is first registered
        bus.BCLK  = 1'b0;
        bus.LRCLK = 1'b0;
        bus.SDATA = pend;
        repeat (4) @(negedge clk);
        bus.BCLK = 1'b1;
        @(posedge clk); #1;
        chk("lat_edge1", 32'(bus.validR), 0);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(bus.validR), 0);
        @(posedge clk); #1;
        chk("lat_edge3", 32'(bus.validR), 1);
        chk("lat_edge3_dataR", 32'(bus.dataR), 32'h0ABC);
        @(posedge clk); #1;
        chk("lat_edge4", 32'(bus.validR), 0);
        @(negedge clk);
        bus.BCLK = 1'b0;
        repeat (20) @(negedge clk);
        chk("final_queue_empty", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
